v_pipe_update: RTL

Update pipeline of the list engine: accepts list update commands (clear/insert/delete/modify) per product ID and read-modify-writes the per-ID state table entry. It is the writer of the state table shared with the query pipeline. It publishes the valid flag and product ID of each in-flight stage (S1..S4) so the query pipeline can flag busy lists. A response carrying status and new list occupancy is returned 4 cycles after acceptance.

---
 rtl/v_pkg.sv | 38 +++
 rtl/v_pipe_update_alu.sv | 58 +++++
 rtl/v_pipe_update.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/v_pkg.sv
// Shared types for the list engine: per-ID state entry, update opcodes and level decode.
package v_pkg;

    localparam int ENTRIES_N = 4;
    localparam int ID_W      = 4;
    localparam int KEY_W     = 8;
    localparam int VOL_W     = 8;
    localparam int LEVEL_W   = $clog2(ENTRIES_N);
    localparam int LS_W      = $clog2(ENTRIES_N + 1);

    typedef logic [ID_W-1:0]    id_t;
    typedef logic [ID_W-1:0]    addr_t;
    typedef logic [LEVEL_W-1:0] level_t;
    typedef logic [KEY_W-1:0]   key_t;
    typedef logic [VOL_W-1:0]   volume_t;
    typedef logic [LS_W-1:0]    listsize_t;

    typedef enum logic [1:0] {
        OP_CLR    = 2'd0,
        OP_INSERT = 2'd1,
        OP_DELETE = 2'd2,
        OP_MODIFY = 2'd3
    } opcode_t;

    typedef struct packed {
        key_t    [ENTRIES_N-1:0] key;
        volume_t [ENTRIES_N-1:0] volume;
        logic    [ENTRIES_N-1:0] vld;
        listsize_t               listsize;
    } state_t;

    // One-hot decode of a level index into the vld bit vector.
    function automatic logic [ENTRIES_N-1:0] dec(input level_t lvl);
        dec      = '0;
        dec[lvl] = 1'b1;
    endfunction

endpackage

// File: rtl/v_pipe_update_alu.sv
// Next-state and error computation for one update command against a source entry.
module v_pipe_update_alu
    import v_pkg::*;
(
    input  opcode_t opcode_i,
    input  level_t  level_i,
    input  key_t    key_i,
    input  volume_t volume_i,
    input  state_t  src_i,
    output state_t  nxt_o,
    output logic    error_o
);

    logic [ENTRIES_N-1:0] lvl_oh;
    logic                 hit;

    assign lvl_oh = dec(level_i);
    assign hit    = |(src_i.vld & lvl_oh);

    // A rejected command leaves the entry exactly as it was sourced.
    always_comb begin
        nxt_o   = src_i;
        error_o = 1'b0;
        case (opcode_i)
            OP_CLR: begin
                nxt_o.vld      = '0;
                nxt_o.listsize = '0;
            end
            OP_INSERT: begin
                if (hit) begin
                    error_o = 1'b1;
                end else begin
                    nxt_o.key[level_i]    = key_i;
                    nxt_o.volume[level_i] = volume_i;
                    nxt_o.vld             = src_i.vld | lvl_oh;
                    nxt_o.listsize        = src_i.listsize + listsize_t'(1);
                end
            end
            OP_DELETE: begin
                if (!hit) begin
                    error_o = 1'b1;
                end else begin
                    nxt_o.vld      = src_i.vld & ~lvl_oh;
                    nxt_o.listsize = src_i.listsize - listsize_t'(1);
                end
            end
            default: begin
                if (!hit) begin
                    error_o = 1'b1;
                end else begin
                    nxt_o.key[level_i]    = key_i;
                    nxt_o.volume[level_i] = volume_i;
                end
            end
        endcase
    end

endmodule

// File: rtl/v_pipe_update.sv
// Four-stage read-modify-write update pipeline for the per-ID list state table.
// Optional macro V_PIPE_UPDATE_FWD_EN: forward in-flight entries instead of stalling on same-ID hazards.
module v_pipe_update
    import v_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      i_upd_vld,
    output logic      o_upd_rdy,
    input  id_t       i_upd_prod_id,
    input  opcode_t   i_upd_opcode,
    input  level_t    i_upd_level,
    input  key_t      i_upd_key,
    input  volume_t   i_upd_volume,
    output logic      o_upd_resp_vld,
    output logic      o_upd_resp_error,
    output listsize_t o_upd_resp_listsize,
    output logic      o_state_ren,
    output addr_t     o_state_raddr,
    input  state_t    i_state_rdata,
    output logic      o_state_wen,
    output addr_t     o_state_waddr,
    output state_t    o_state_wdata,
    output logic      o_s1_upd_vld_r,
    output id_t       o_s1_upd_prod_id_r,
    output logic      o_s2_upd_vld_r,
    output id_t       o_s2_upd_prod_id_r,
    output logic      o_s3_upd_vld_r,
    output id_t       o_s3_upd_prod_id_r,
    output logic      o_s4_upd_vld_r,
    output id_t       o_s4_upd_prod_id_r
);

    // Handshake: a command transfers on a rising edge where i_upd_vld & o_upd_rdy;
    // the response pulses exactly once, four cycles later, unless reset intervenes.
    logic    accept;
    logic    s1_vld_q, s2_vld_q, s3_vld_q, s4_vld_q;
    id_t     s1_id_q, s2_id_q, s3_id_q, s4_id_q;
    opcode_t s1_op_q;
    level_t  s1_level_q;
    key_t    s1_key_q;
    volume_t s1_volume_q;
    state_t  s1_src;
    state_t  s2_state_d, s2_state_q, s3_state_q;
    logic    s2_error_d, s2_error_q, s3_error_q, s4_error_q;
    listsize_t s4_listsize;

    assign accept = i_upd_vld & o_upd_rdy;

`ifdef V_PIPE_UPDATE_FWD_EN
    state_t s4_state_q;

    assign o_upd_rdy = ~rst;

    // Later assignments win, so the youngest matching older stage is chosen.
    always_comb begin
        s1_src = i_state_rdata;
        if (s4_vld_q && s4_id_q == s1_id_q) s1_src = s4_state_q;
        if (s3_vld_q && s3_id_q == s1_id_q) s1_src = s3_state_q;
        if (s2_vld_q && s2_id_q == s1_id_q) s1_src = s2_state_q;
    end

    always_ff @(posedge clk) s4_state_q <= s3_state_q;
    assign s4_listsize = s4_state_q.listsize;
`else
    logic      hazard;
    listsize_t s4_listsize_q;

    // S4 is excluded: its write landed in the cycle the new read is issued.
    assign hazard = (s1_vld_q && s1_id_q == i_upd_prod_id)
                  | (s2_vld_q && s2_id_q == i_upd_prod_id)
                  | (s3_vld_q && s3_id_q == i_upd_prod_id);
    assign o_upd_rdy = ~rst & ~hazard;
    assign s1_src    = i_state_rdata;

    always_ff @(posedge clk) s4_listsize_q <= s3_state_q.listsize;
    assign s4_listsize = s4_listsize_q;
`endif

    v_pipe_update_alu u_alu (
        .opcode_i (s1_op_q),
        .level_i  (s1_level_q),
        .key_i    (s1_key_q),
        .volume_i (s1_volume_q),
        .src_i    (s1_src),
        .nxt_o    (s2_state_d),
        .error_o  (s2_error_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q <= 1'b0;
            s2_vld_q <= 1'b0;
            s3_vld_q <= 1'b0;
            s4_vld_q <= 1'b0;
        end else begin
            s1_vld_q <= accept;
            s2_vld_q <= s1_vld_q;
            s3_vld_q <= s2_vld_q;
            s4_vld_q <= s3_vld_q;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            s1_id_q     <= i_upd_prod_id;
            s1_op_q     <= i_upd_opcode;
            s1_level_q  <= i_upd_level;
            s1_key_q    <= i_upd_key;
            s1_volume_q <= i_upd_volume;
        end
        s2_id_q    <= s1_id_q;
        s2_state_q <= s2_state_d;
        s2_error_q <= s2_error_d;
        s3_id_q    <= s2_id_q;
        s3_state_q <= s2_state_q;
        s3_error_q <= s2_error_q;
        s4_id_q    <= s3_id_q;
        s4_error_q <= s3_error_q;
    end

    assign o_state_ren   = accept;
    assign o_state_raddr = i_upd_prod_id;

    assign o_state_wen   = s3_vld_q & ~s3_error_q & ~rst;
    assign o_state_waddr = s3_id_q;
    assign o_state_wdata = s3_state_q;

    assign o_upd_resp_vld      = s4_vld_q;
    assign o_upd_resp_error    = s4_vld_q & s4_error_q;
    assign o_upd_resp_listsize = s4_vld_q ? s4_listsize : '0;

    assign o_s1_upd_vld_r     = s1_vld_q;
    assign o_s1_upd_prod_id_r = s1_id_q;
    assign o_s2_upd_vld_r     = s2_vld_q;
    assign o_s2_upd_prod_id_r = s2_id_q;
    assign o_s3_upd_vld_r     = s3_vld_q;
    assign o_s3_upd_prod_id_r = s3_id_q;
    assign o_s4_upd_vld_r     = s4_vld_q;
    assign o_s4_upd_prod_id_r = s4_id_q;

endmodule
